// File: rtl/instruction_decode.sv
// Decode stage: assembles one- or two-byte instructions from the fetch byte
// stream and holds the decoded bundle until the execute stage acknowledges it.
module instruction_decode #(
    parameter logic [15:0] IMM_MASK     = 16'h0702,
    parameter logic [15:0] ILLEGAL_MASK = 16'hC000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       DIR,
    input  logic [7:0] data_in,
    output logic       ack_to_IF,
    output logic       DOR,
    input  logic       ack_to_ID,
    input  logic       flush,
    output logic [3:0] opcode,
    output logic [1:0] rd,
    output logic [1:0] rs,
    output logic [7:0] imm,
    output logic       has_imm,
    output logic       illegal
);
    localparam int unsigned OP_W  = 4;
    localparam int unsigned REG_W = 2;
    localparam int unsigned IMM_W = 8;

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        HOLD      = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               ack_q, ack_d;
    logic               dor_q, dor_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic [REG_W-1:0]   rs_q, rs_d;
    logic [IMM_W-1:0]   imm_q, imm_d;
    logic               has_imm_q, has_imm_d;
    logic               illegal_q, illegal_d;
    logic               capture;

    // State and bundle registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= FETCH_OP;
            ack_q     <= 1'b0;
            dor_q     <= 1'b0;
            opcode_q  <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            imm_q     <= '0;
            has_imm_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dor_q     <= dor_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            imm_q     <= imm_d;
            has_imm_q <= has_imm_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and bundle assembly; a byte is never taken while its ack is still high.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        dor_d     = dor_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        imm_d     = imm_q;
        has_imm_d = has_imm_q;
        illegal_d = illegal_q;
        capture   = DIR && !ack_q && !flush && (state_q != HOLD);

        if (flush) begin
            state_d   = FETCH_OP;
            dor_d     = 1'b0;
            opcode_d  = '0;
            rd_d      = '0;
            rs_d      = '0;
            imm_d     = '0;
            has_imm_d = 1'b0;
            illegal_d = 1'b0;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (capture) begin
                        ack_d     = 1'b1;
                        opcode_d  = data_in[7:4];
                        rd_d      = data_in[3:2];
                        rs_d      = data_in[1:0];
                        imm_d     = '0;
                        illegal_d = ILLEGAL_MASK[data_in[7:4]];
                        if (ILLEGAL_MASK[data_in[7:4]]) begin
                            has_imm_d = 1'b0;
                            state_d   = HOLD;
                            dor_d     = 1'b1;
                        end else if (IMM_MASK[data_in[7:4]]) begin
                            has_imm_d = 1'b1;
                            state_d   = FETCH_IMM;
                        end else begin
                            has_imm_d = 1'b0;
                            state_d   = HOLD;
                            dor_d     = 1'b1;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (capture) begin
                        ack_d   = 1'b1;
                        imm_d   = data_in;
                        state_d = HOLD;
                        dor_d   = 1'b1;
                    end
                end
                HOLD: begin
                    if (ack_to_ID) begin
                        state_d = FETCH_OP;
                        dor_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = FETCH_OP;
                    dor_d   = 1'b0;
                end
            endcase
        end
    end

    assign ack_to_IF = ack_q;
    assign DOR       = dor_q;
    assign opcode    = opcode_q;
    assign rd        = rd_q;
    assign rs        = rs_q;
    assign imm       = imm_q;
    assign has_imm   = has_imm_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: a bundle-level reference model is
// compared every cycle, plus literal checks on each scenario.
module tb_instruction_decode;
    localparam logic [15:0] IMM_M = 16'h0702;
    localparam logic [15:0] ILL_M = 16'hC000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       DIR = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ack_to_IF;
    logic       DOR;
    logic       ack_to_ID = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] opcode;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       has_imm;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    instruction_decode dut (
        .clk(clk), .reset(reset), .DIR(DIR), .data_in(data_in),
        .ack_to_IF(ack_to_IF), .DOR(DOR), .ack_to_ID(ack_to_ID), .flush(flush),
        .opcode(opcode), .rd(rd), .rs(rs), .imm(imm), .has_imm(has_imm),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: tracks the expected bundle in terms of bytes taken and bundle ownership.
    logic       armed = 1'b0;
    logic       m_ack = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_wait_imm = 1'b0;
    logic [7:0] m_first = 8'h00;
    logic [7:0] m_imm = 8'h00;
    logic       m_has_imm = 1'b0;
    logic       m_ill = 1'b0;
    logic       m_clear = 1'b1;

    always @(posedge clk) begin
        logic take;
        if (!reset) begin
            armed = 1'b1;
            m_ack = 1'b0; m_valid = 1'b0; m_wait_imm = 1'b0;
            m_first = 8'h00; m_imm = 8'h00; m_has_imm = 1'b0; m_ill = 1'b0;
        end else begin
            take = DIR && !m_ack && !flush && !m_valid;
            if (flush) begin
                m_valid = 1'b0; m_wait_imm = 1'b0;
                m_first = 8'h00; m_imm = 8'h00; m_has_imm = 1'b0; m_ill = 1'b0;
            end else if (m_valid) begin
                if (ack_to_ID) m_valid = 1'b0;
            end else if (take) begin
                if (m_wait_imm) begin
                    m_imm = data_in;
                    m_wait_imm = 1'b0;
                    m_valid = 1'b1;
                end else begin
                    m_first = data_in;
                    m_imm = 8'h00;
                    m_ill = ILL_M[data_in[7:4]];
                    m_has_imm = !m_ill && IMM_M[data_in[7:4]];
                    m_wait_imm = m_has_imm;
                    m_valid = !m_has_imm;
                end
            end
            m_ack = take;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("m_ack", 32'(ack_to_IF), 32'(m_ack));
            chk("m_dor", 32'(DOR), 32'(m_valid));
            chk("m_opcode", 32'(opcode), 32'(m_first[7:4]));
            chk("m_rd", 32'(rd), 32'(m_first[3:2]));
            chk("m_rs", 32'(rs), 32'(m_first[1:0]));
            chk("m_imm", 32'(imm), 32'(m_imm));
            chk("m_has_imm", 32'(has_imm), 32'(m_has_imm));
            chk("m_illegal", 32'(illegal), 32'(m_ill));
        end
    end

    // Present a byte and wait (bounded) for its ack; leaves DIR low afterwards.
    task automatic send(input logic [7:0] b);
        int n;
        DIR = 1'b1;
        data_in = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_to_IF && n < 20);
        chk("ack_seen", 32'(ack_to_IF), 32'd1);
        DIR = 1'b0;
    endtask

    task automatic release_bundle();
        ack_to_ID = 1'b1;
        @(negedge clk);
        ack_to_ID = 1'b0;
        chk("release_dor", 32'(DOR), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dor", 32'(DOR), 32'd0);
        chk("rst_bundle", {ack_to_IF, opcode, rd, rs, imm, has_imm, illegal}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single-byte instruction 0x2D.
        send(8'h2D);
        chk("t1_dor_with_ack", 32'(DOR), 32'd1);
        chk("t1_fields", {opcode, rd, rs, has_imm, imm}, {4'h2, 2'd3, 2'd1, 1'b0, 8'h00});
        @(negedge clk);
        chk("t1_ack_drop", 32'(ack_to_IF), 32'd0);
        chk("t1_dor_held", 32'(DOR), 32'd1);
        release_bundle();

        // Two-byte instruction 0x14, 0xA5.
        send(8'h14);
        chk("t2_dor_mid", 32'(DOR), 32'd0);
        @(negedge clk);
        chk("t2_dor_gap", 32'(DOR), 32'd0);
        send(8'hA5);
        chk("t2_fields", {DOR, opcode, rd, rs, has_imm, imm}, {1'b1, 4'h1, 2'd1, 2'd0, 1'b1, 8'hA5});
        release_bundle();

        // Backpressure: 0x40 waits behind a held 0x30 bundle.
        send(8'h30);
        DIR = 1'b1;
        data_in = 8'h40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_no_ack", 32'(ack_to_IF), 32'd0);
            chk("t3_stable", {DOR, opcode}, {1'b1, 4'h3});
        end
        ack_to_ID = 1'b1;
        @(negedge clk);
        ack_to_ID = 1'b0;
        chk("t3_consume", {DOR, ack_to_IF}, 32'd0);
        @(negedge clk);
        chk("t3_take40", {ack_to_IF, DOR, opcode}, {1'b1, 1'b1, 4'h4});
        DIR = 1'b0;
        release_bundle();

        // Illegal opcode 0xF0 followed by 0x55.
        send(8'hF0);
        chk("t4_illegal", {DOR, illegal, has_imm, imm}, {1'b1, 1'b1, 1'b0, 8'h00});
        DIR = 1'b1;
        data_in = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_ack", 32'(ack_to_IF), 32'd0);
        end
        release_bundle();
        chk("t4_no_take_on_consume", 32'(ack_to_IF), 32'd0);
        @(negedge clk);
        chk("t4_take55", {ack_to_IF, DOR, opcode, rd, rs, illegal},
            {1'b1, 1'b1, 4'h5, 2'd1, 2'd1, 1'b0});
        DIR = 1'b0;
        release_bundle();

        // Flush while waiting for an immediate.
        send(8'h80);
        chk("t5_wait_imm", {DOR, has_imm, opcode}, {1'b0, 1'b1, 4'h8});
        @(negedge clk);
        flush = 1'b1;
        DIR = 1'b1;
        data_in = 8'h77;
        @(negedge clk);
        flush = 1'b0;
        chk("t5_flush", {ack_to_IF, DOR, opcode, has_imm}, 32'd0);
        @(negedge clk);
        chk("t5_take77", {ack_to_IF, DOR, opcode, rd, rs, has_imm},
            {1'b1, 1'b1, 4'h7, 2'd1, 2'd3, 1'b0});
        DIR = 1'b0;

        // Reset while holding a bundle.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_reset", {ack_to_IF, DOR, opcode, rd, rs, imm, has_imm, illegal}, 32'd0);
        send(8'h2D);
        chk("t6_as_opcode", {DOR, opcode}, {1'b1, 4'h2});
        release_bundle();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
